// File: rtl/guess_evaluator.sv
// Round-based BCD guess checker: compares player guesses to a registered target.
// Define GUESS_ATTEMPT_LIMIT_EN to cap each round at 8 wrong guesses (adds missed).
module guess_evaluator (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       submit,
  input  logic [3:0] guess_digit_1,
  input  logic [3:0] guess_digit_2,
  input  logic [3:0] guess_digit_3,
  input  logic [3:0] target_digit_1,
  input  logic [3:0] target_digit_2,
  input  logic [3:0] target_digit_3,
  output logic [3:0] round,
  output logic [1:0] Max_digit,
  output logic [1:0] result,
  output logic       result_valid,
  output logic [3:0] attempts,
  output logic       game_over
`ifdef GUESS_ATTEMPT_LIMIT_EN
  ,output logic      missed
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_GUESS,
    COMPARE,
    NEXT,
    DONE
  } state_t;

  state_t     r_state, w_state;
  logic       r_load, w_load;
  logic [3:0] r_round, w_round;
  logic [1:0] r_maxd, w_maxd;
  logic [1:0] r_result, w_result;
  logic       r_valid, w_valid;
  logic [3:0] r_att, w_att;
  logic       r_over, w_over;
  logic [11:0] r_guess, w_guess;
`ifdef GUESS_ATTEMPT_LIMIT_EN
  logic       r_missed, w_missed;
`endif

  logic [11:0] w_target;
  logic        w_bad;
  logic        w_lt;
  logic        w_eq;
  logic [3:0]  w_att_inc;
  logic [3:0]  w_round_inc;

  function automatic logic [1:0] maxd_of(input logic [3:0] rnd);
    if (rnd == 4'd0)      return 2'b00;
    else if (rnd <= 4'd3) return 2'b01;
    else if (rnd <= 4'd6) return 2'b10;
    else                  return 2'b11;
  endfunction

  assign w_target = {target_digit_3, target_digit_2, target_digit_1};
  assign w_bad = (r_guess[3:0] > 4'd9) ||
                 (r_guess[7:4] > 4'd9) ||
                 (r_guess[11:8] > 4'd9);
  // Packed BCD nibbles order the same way as the decimal value.
  assign w_lt = r_guess < w_target;
  assign w_eq = r_guess == w_target;
  assign w_att_inc = (r_att == 4'd15) ? r_att : r_att + 4'd1;
  assign w_round_inc = r_round + 4'd1;

  always_comb begin
    w_state  = r_state;
    w_load   = r_load;
    w_round  = r_round;
    w_maxd   = r_maxd;
    w_result = r_result;
    w_valid  = 1'b0;
    w_att    = r_att;
    w_over   = r_over;
    w_guess  = r_guess;
`ifdef GUESS_ATTEMPT_LIMIT_EN
    w_missed = 1'b0;
`endif
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_round = 4'd1;
          w_maxd  = 2'b01;
          w_over  = 1'b0;
          w_load  = 1'b0;
          w_state = LOAD;
        end
      end
      LOAD: begin
        if (r_load) w_state = WAIT_GUESS;
        else        w_load  = 1'b1;
      end
      WAIT_GUESS: begin
        if (submit) begin
          w_guess = {guess_digit_3, guess_digit_2, guess_digit_1};
          w_state = COMPARE;
        end
      end
      COMPARE: begin
        w_valid = 1'b1;
        w_state = WAIT_GUESS;
        if (w_bad) begin
          w_result = 2'b00;
        end else if (w_eq) begin
          w_result = 2'b11;
          w_state  = NEXT;
        end else begin
          w_result = w_lt ? 2'b01 : 2'b10;
          w_att    = w_att_inc;
`ifdef GUESS_ATTEMPT_LIMIT_EN
          if (r_att == 4'd7) begin
            w_missed = 1'b1;
            w_state  = NEXT;
          end
`endif
        end
      end
      NEXT: begin
        w_att = 4'd0;
        if (r_round < 4'd9) begin
          w_round = w_round_inc;
          w_maxd  = maxd_of(w_round_inc);
          w_load  = 1'b0;
          w_state = LOAD;
        end else begin
          w_over  = 1'b1;
          w_state = DONE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_load   <= 1'b0;
      r_round  <= 4'd0;
      r_maxd   <= 2'b00;
      r_result <= 2'b00;
      r_valid  <= 1'b0;
      r_att    <= 4'd0;
      r_over   <= 1'b0;
      r_guess  <= 12'd0;
`ifdef GUESS_ATTEMPT_LIMIT_EN
      r_missed <= 1'b0;
`endif
    end else begin
      r_state  <= w_state;
      r_load   <= w_load;
      r_round  <= w_round;
      r_maxd   <= w_maxd;
      r_result <= w_result;
      r_valid  <= w_valid;
      r_att    <= w_att;
      r_over   <= w_over;
      r_guess  <= w_guess;
`ifdef GUESS_ATTEMPT_LIMIT_EN
      r_missed <= w_missed;
`endif
    end
  end

  assign round        = r_round;
  assign Max_digit    = r_maxd;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign attempts     = r_att;
  assign game_over    = r_over;
`ifdef GUESS_ATTEMPT_LIMIT_EN
  assign missed       = r_missed;
`endif

endmodule

// File: tb/tb_guess_evaluator.sv
// Random-stimulus bench for guess_evaluator against a decimal game model.
// Includes a registered target-number stage driven from the DUT round.
module tb_guess_evaluator;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic [3:0] gd1 = '0, gd2 = '0, gd3 = '0;
  logic [3:0] td1 = '0, td2 = '0, td3 = '0;
  logic [3:0] round;
  logic [1:0] maxd;
  logic [1:0] result;
  logic       rv;
  logic [3:0] attempts;
  logic       game_over;
`ifdef GUESS_ATTEMPT_LIMIT_EN
  logic       missed;
`endif

  int n_chk = 0;
  int n_err = 0;
  int tgt_tab [10];
  int t_cur;
  int m_round = 0;
  int m_att = 0;
  bit m_over = 0;

  guess_evaluator dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .submit         (submit),
    .guess_digit_1  (gd1),
    .guess_digit_2  (gd2),
    .guess_digit_3  (gd3),
    .target_digit_1 (td1),
    .target_digit_2 (td2),
    .target_digit_3 (td3),
    .round          (round),
    .Max_digit      (maxd),
    .result         (result),
    .result_valid   (rv),
    .attempts       (attempts),
    .game_over      (game_over)
`ifdef GUESS_ATTEMPT_LIMIT_EN
    ,.missed        (missed)
`endif
  );

  always #5 clk = ~clk;

  // Target-number stage: registers the target one clk after round changes.
  always @(posedge clk) begin
    t_cur = (round <= 4'd9) ? tgt_tab[round] : 0;
    td3 <= 4'(t_cur / 100);
    td2 <= 4'((t_cur / 10) % 10);
    td1 <= 4'(t_cur % 10);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_maxd(input int r);
    if (r == 0) return 0;
    if (r <= 3) return 1;
    if (r <= 6) return 2;
    return 3;
  endfunction

  function automatic int ref_res(input int g3, input int g2,
                                 input int g1, input int t);
    int gv;
    if (g3 > 9 || g2 > 9 || g1 > 9) return 0;
    gv = 100 * g3 + 10 * g2 + g1;
    if (gv < t) return 1;
    if (gv > t) return 2;
    return 3;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_round"}, round, 0);
    chk({tag, "_maxd"}, maxd, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_rv"}, rv, 0);
    chk({tag, "_att"}, attempts, 0);
    chk({tag, "_over"}, game_over, 0);
  endtask

  // Submits held through both LOAD cycles must be ignored.
  task automatic load_wait();
    gd1 = 4'($urandom_range(0, 9));
    gd2 = 4'($urandom_range(0, 9));
    gd3 = 4'($urandom_range(0, 9));
    submit = 1'b1;
    tick();
    chk("load_rv", rv, 0);
    tick();
    chk("load_rv", rv, 0);
    submit = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_round = 1;
    m_att = 0;
    m_over = 0;
    chk("start_round", round, 1);
    chk("start_maxd", maxd, 1);
    chk("start_over", game_over, 0);
    load_wait();
  endtask

  task automatic guess(input int g3, input int g2, input int g1,
                       input bit with_start);
    int e;
    bit adv;
    e = ref_res(g3, g2, g1, tgt_tab[m_round]);
    gd3 = 4'(g3);
    gd2 = 4'(g2);
    gd1 = 4'(g1);
    submit = 1'b1;
    start = with_start;
    tick();
    submit = 1'b0;
    start = 1'b0;
    chk("cmp_rv", rv, 0);
    tick();
    chk("rv", rv, 1);
    chk("result", result, e);
    adv = (e == 3);
    if (e == 1 || e == 2) begin
      if (m_att < 15) m_att++;
`ifdef GUESS_ATTEMPT_LIMIT_EN
      if (m_att == 8) adv = 1;
`endif
    end
    chk("attempts", attempts, m_att);
`ifdef GUESS_ATTEMPT_LIMIT_EN
    chk("missed", missed, int'(adv && e != 3));
`endif
    if (adv) begin
      tick();
      chk("next_rv", rv, 0);
      m_att = 0;
      if (m_round < 9) m_round++;
      else m_over = 1;
      chk("next_round", round, m_round);
      chk("next_maxd", maxd, exp_maxd(m_round));
      chk("next_att", attempts, 0);
      chk("next_over", game_over, int'(m_over));
      if (!m_over) load_wait();
    end
  endtask

  task automatic wrong_guess(input bit allow_bad, input bit with_start);
    int n, lim, g3, g2, g1, k;
    if (allow_bad && $urandom_range(0, 3) == 0) begin
      g3 = $urandom_range(0, 9);
      g2 = $urandom_range(0, 9);
      g1 = $urandom_range(0, 9);
      k = $urandom_range(0, 2);
      if (k == 0) g1 = $urandom_range(10, 15);
      else if (k == 1) g2 = $urandom_range(10, 15);
      else g3 = $urandom_range(10, 15);
      guess(g3, g2, g1, with_start);
    end else begin
      lim = (m_round <= 3) ? 9 : (m_round <= 6) ? 99 : 999;
      n = $urandom_range(0, lim);
      if (n == tgt_tab[m_round]) n = (n + 1) % (lim + 1);
      guess(n / 100, (n / 10) % 10, n % 10, with_start);
    end
  endtask

  task automatic correct();
    int t;
    t = tgt_tab[m_round];
    guess(t / 100, (t / 10) % 10, t % 10, 0);
  endtask

  initial begin
    int k;
    bit did57;
    did57 = 0;
    tgt_tab[0] = 0;
    tgt_tab[1] = 2;
    tgt_tab[2] = $urandom_range(0, 9);
    tgt_tab[3] = $urandom_range(0, 9);
    tgt_tab[4] = 57;
    tgt_tab[5] = $urandom_range(0, 99);
    tgt_tab[6] = $urandom_range(0, 99);
    tgt_tab[7] = $urandom_range(0, 999);
    tgt_tab[8] = $urandom_range(0, 999);
    tgt_tab[9] = 999;

    tick();
    tick();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    tick();
    chk("idle_round", round, 0);
    submit = 1'b1;
    tick();
    tick();
    submit = 1'b0;
    chk("idle_sub_rv", rv, 0);

    do_start();
    guess(0, 0, 1, 0);
    guess(0, 12, 5, 0);
    guess(0, 0, 2, 0);

    for (int i = 0; i < 16; i++) wrong_guess(0, 0);
`ifndef GUESS_ATTEMPT_LIMIT_EN
    chk("sat_att", attempts, 15);
    chk("sat_round", round, 2);
    correct();
`endif

    while (!m_over) begin
      if (m_round == 4 && !did57) begin
        guess(0, 6, 0, 0);
        did57 = 1;
      end
      k = $urandom_range(0, 4);
      for (int i = 0; i < k; i++) wrong_guess(1, (i == 0));
      correct();
    end

    chk("done_over", game_over, 1);
    chk("done_round", round, 9);
    gd3 = 4'd9;
    gd2 = 4'd9;
    gd1 = 4'd9;
    submit = 1'b1;
    tick();
    tick();
    submit = 1'b0;
    chk("done_sub_rv", rv, 0);
    chk("done_hold_round", round, 9);
    chk("done_hold_over", game_over, 1);

    do_start();
    guess(0, 0, 5, 0);

    gd3 = 4'd0;
    gd2 = 4'd0;
    gd1 = 4'd1;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    m_round = 0;
    m_att = 0;
    m_over = 0;
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    chk("post_rst_round", round, 0);
    chk("post_rst_rv", rv, 0);
    submit = 1'b1;
    tick();
    tick();
    submit = 1'b0;
    chk("post_rst_sub_rv", rv, 0);
    do_start();
    correct();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
